// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cnn_pkg
// Brief    : Shared types and helpers for the CNN datapath stages: default
//            data width, pooling-stage state encoding, signed max and the
//            output-address width helper.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int DATA_W_DEF = 16;

  // Widest operand the max helper handles; callers sign-extend into it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } pool_state_e;

  // Signed max; narrower operands are sign-extended in and truncated back out.
  function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                   input logic signed [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to address (h/2)*(w/2) pooled outputs (never less than 1).
  function automatic int oaddr_w(input int h, input int w);
    int n;
    n = (h / 2) * (w / 2);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pool_line_buffer
// Brief    : One-row store of horizontal partial maxima. DEPTH entries of
//            DATA_W bits, one synchronous write port and one asynchronous
//            read port, both indexed by column-pair number.
// Revision : 1.0 - initial release
// ============================================================================
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 14,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic signed [DATA_W-1:0] o_rdata
);

  // No reset: every entry is rewritten on an even row before the odd row reads it.
  logic signed [DATA_W-1:0] r_mem [DEPTH];

  // Capture one partial max per column pair while on an even row.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/relu_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool2x2
// Brief    : Streaming ReLU + 2x2/stride-2 max-pool over one HxW channel in
//            raster order. Horizontal pair maxima of even rows are parked in a
//            line buffer and combined with the odd-row pair maxima.
// Config   : define POOL_RELU_EN to clamp negative inputs to zero before
//            pooling; otherwise the stage is a pure signed max-pool.
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool2x2
  import cnn_pkg::*;
#(
  parameter int H       = 28,
  parameter int W       = 28,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,          // asynchronous, active-low
  input  logic                     i_in_valid,
  input  logic signed [DATA_W-1:0] i_in_data,
  input  logic                     i_in_last,
  output logic                     o_in_ready,
  output logic                     o_out_valid,
  output logic signed [DATA_W-1:0] o_out_data,
  output logic [OADDR_W-1:0]       o_out_addr,
  input  logic                     i_out_ready,
  output logic                     o_done,
  output logic                     o_err
);

  localparam int RW    = (H > 2) ? $clog2(H) : 1;
  localparam int CW    = (W > 2) ? $clog2(W) : 1;
  localparam int LB_AW = (W > 2) ? $clog2(W / 2) : 1;

  pool_state_e              r_state, w_state_nxt;
  logic [RW-1:0]            r_row;
  logic [CW-1:0]            r_col;
  logic signed [DATA_W-1:0] r_hold;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic [OADDR_W-1:0]       r_out_addr;
  logic                     r_err;

  logic                     w_in_ready, w_accept;
  logic                     w_col_end, w_row_end, w_frame_end;
  logic signed [DATA_W-1:0] w_v, w_hmax, w_pmax, w_lb_rdata;
  logic                     w_lb_we, w_produce;
  logic [LB_AW-1:0]         w_lb_idx;
  logic [OADDR_W-1:0]       w_addr;

`ifdef POOL_RELU_EN
  assign w_v = i_in_data[DATA_W-1] ? '0 : i_in_data;
`else
  assign w_v = i_in_data;
`endif

  // Single output register with no skid: a new beat only when it can be vacated.
  assign w_in_ready  = (r_state == ST_RUN) && (!r_out_valid || i_out_ready);
  assign w_accept    = i_in_valid && w_in_ready;

  assign w_col_end   = (r_col == CW'(W - 1));
  assign w_row_end   = (r_row == RW'(H - 1));
  assign w_frame_end = w_col_end && w_row_end;

  assign w_lb_idx    = LB_AW'(r_col >> 1);
  assign w_hmax      = DATA_W'(smax(MAX_W'(r_hold), MAX_W'(w_v)));
  assign w_pmax      = DATA_W'(smax(MAX_W'(w_lb_rdata), MAX_W'(w_hmax)));
  assign w_lb_we     = w_accept && r_col[0] && !r_row[0];
  assign w_produce   = w_accept && r_col[0] && r_row[0];
  assign w_addr      = OADDR_W'((r_row >> 1) * (W / 2) + (r_col >> 1));

  pool_line_buffer #(
    .DEPTH  (W / 2),
    .DATA_W (DATA_W),
    .AW     (LB_AW)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_idx),
    .i_wdata (w_hmax),
    .i_raddr (w_lb_idx),
    .o_rdata (w_lb_rdata)
  );

  // Channel sequencing state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: drain the output register after in_last, then pulse done once.
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    case (r_state)
      ST_RUN:   if (w_accept && i_in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_out_valid || i_out_ready) w_state_nxt = ST_DONE;
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Raster counters, even-column hold and sticky framing error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_hold <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      if (i_in_last) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (!r_col[0]) begin
        r_hold <= w_v;
      end
      if (i_in_last != w_frame_end) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output register: loaded on an odd/odd beat, otherwise emptied by the consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else if (w_produce) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_pmax;
      r_out_addr  <= w_addr;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool2x2
// Brief    : Self-checking bench for relu_maxpool2x2: a 4x4 instance for the
//            directed scenarios and a default 28x28 instance for a random
//            stream with random back-pressure. Expected pooled values come
//            from a direct 4-way max over the driven pixels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool2x2;
  import cnn_pkg::*;

  localparam int DW  = 16;
  localparam int AH  = 4;
  localparam int AW  = 4;
  localparam int AOW = oaddr_w(AH, AW);
  localparam int BH  = 28;
  localparam int BW  = 28;
  localparam int BOW = 8;

  typedef struct {
    int data;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                 a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b1;
  logic signed [DW-1:0] a_in_data  = '0;
  logic                 a_in_ready, a_out_valid, a_done, a_err;
  logic signed [DW-1:0] a_out_data;
  logic [AOW-1:0]       a_out_addr;

  logic                 b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
  logic signed [DW-1:0] b_in_data  = '0;
  logic                 b_in_ready, b_out_valid, b_done, b_err;
  logic signed [DW-1:0] b_out_data;
  logic [BOW-1:0]       b_out_addr;

  int   checks = 0;
  int   failures = 0;
  int   a_done_cnt = 0, b_done_cnt = 0, b_out_cnt = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;
  logic signed [DW-1:0] fa [AH*AW];
  logic signed [DW-1:0] fb [BH*BW];

  relu_maxpool2x2 #(.H(AH), .W(AW), .DATA_W(DW), .OADDR_W(AOW)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_in_valid(a_in_valid), .i_in_data(a_in_data), .i_in_last(a_in_last),
    .o_in_ready(a_in_ready), .o_out_valid(a_out_valid), .o_out_data(a_out_data),
    .o_out_addr(a_out_addr), .i_out_ready(a_out_ready), .o_done(a_done), .o_err(a_err)
  );

  relu_maxpool2x2 #(.H(BH), .W(BW), .DATA_W(DW), .OADDR_W(BOW)) u_dut28 (
    .clk(clk), .rst(rst),
    .i_in_valid(b_in_valid), .i_in_data(b_in_data), .i_in_last(b_in_last),
    .o_in_ready(b_in_ready), .o_out_valid(b_out_valid), .o_out_data(b_out_data),
    .o_out_addr(b_out_addr), .i_out_ready(b_out_ready), .o_done(b_done), .o_err(b_err)
  );

  always #5 clk = ~clk;

  function automatic int relu_m(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int max4(input int p, input int q, input int s, input int t);
    int m;
    m = relu_m(p);
    if (relu_m(q) > m) m = relu_m(q);
    if (relu_m(s) > m) m = relu_m(s);
    if (relu_m(t) > m) m = relu_m(t);
    return m;
  endfunction

  // Scoreboard pop/compare for the 4x4 instance on each output handshake.
  always @(negedge clk) begin
    if (rst && a_out_valid && a_out_ready) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_out_unexpected got data=%0d addr=%0d want no output", a_out_data, a_out_addr);
      end else begin
        ea = exp_a.pop_front();
        if (int'(a_out_data) !== ea.data || int'(a_out_addr) !== ea.addr) begin
          failures++;
          $display("FAIL a_out got data=%0d addr=%0d want data=%0d addr=%0d",
                   a_out_data, a_out_addr, ea.data, ea.addr);
        end
      end
    end
    if (rst && a_done) a_done_cnt++;
  end

  // Scoreboard pop/compare for the 28x28 instance.
  always @(negedge clk) begin
    if (rst && b_out_valid && b_out_ready) begin
      checks++;
      b_out_cnt++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_out_unexpected got data=%0d addr=%0d want no output", b_out_data, b_out_addr);
      end else begin
        eb = exp_b.pop_front();
        if (int'(b_out_data) !== eb.data || int'(b_out_addr) !== eb.addr) begin
          failures++;
          $display("FAIL b_out got data=%0d addr=%0d want data=%0d addr=%0d",
                   b_out_data, b_out_addr, eb.data, eb.addr);
        end
      end
    end
    if (rst && b_done) b_done_cnt++;
  end

  task automatic send_a(input logic signed [DW-1:0] d, input bit last);
    int n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
    if (!a_in_ready) begin
      checks++; failures++;
      $display("FAIL a_in_ready_timeout got ready=0 for 200 cycles want ready=1");
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic send_b(input logic signed [DW-1:0] d, input bit last);
    int n = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
    @(negedge clk);
    while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
    if (!b_in_ready) begin
      checks++; failures++;
      $display("FAIL b_in_ready_timeout got ready=0 for 200 cycles want ready=1");
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  // Drives nbeats pixels of fa, pushing the expected pooled value as each odd/odd beat goes out.
  task automatic drive_frame_a(input int nbeats, input int last_idx);
    for (int i = 0; i < nbeats; i++) begin
      int r = i / AW;
      int c = i % AW;
      if ((r % 2 == 1) && (c % 2 == 1))
        exp_a.push_back(exp_t'{max4(fa[i-AW-1], fa[i-AW], fa[i-1], fa[i]), (r/2)*(AW/2) + c/2});
      send_a(fa[i], i == last_idx);
    end
  endtask

  task automatic wait_a(input int cnt0);
    int n = 0;
    while (a_done_cnt == cnt0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
    if (a_out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", a_out_data); end
    if (a_out_addr !== '0) begin failures++; $display("FAIL reset_out_addr got=%0d want=0", a_out_addr); end
    if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", a_done); end
    if (a_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", a_err); end
    if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b want=1", b_in_ready); end
    if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%b want=0", b_out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    int cnt0 = a_done_cnt;
    for (int i = 0; i < AH*AW; i++) fa[i] = DW'(i);
    a_out_ready = 1'b1;
    drive_frame_a(AH*AW, AH*AW-1);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_done !== 1'b0) begin
      failures++; $display("FAIL ramp_last_out got valid=%b done=%b want valid=1 done=0", a_out_valid, a_done);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1) begin failures++; $display("FAIL ramp_done_pulse got=%b want=1", a_done); end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) begin failures++; $display("FAIL ramp_done_width got=%b want=0", a_done); end
    wait_a(cnt0);
    checks += 3;
    if (exp_a.size() != 0) begin failures++; $display("FAIL ramp_missing got pending=%0d want 0", exp_a.size()); end
    if (a_done_cnt != cnt0 + 1) begin failures++; $display("FAIL ramp_done_count got=%0d want=%0d", a_done_cnt - cnt0, 1); end
    if (a_err !== 1'b0) begin failures++; $display("FAIL ramp_err got=%b want=0", a_err); end
  endtask

  task automatic test_negative();
    int cnt0 = a_done_cnt;
    for (int i = 0; i < AH*AW; i++) fa[i] = -DW'(3);
    drive_frame_a(AH*AW, AH*AW-1);
    wait_a(cnt0);
    checks += 2;
    if (exp_a.size() != 0) begin failures++; $display("FAIL neg_missing got pending=%0d want 0", exp_a.size()); end
    if (a_done_cnt != cnt0 + 1) begin failures++; $display("FAIL neg_done_count got=%0d want=1", a_done_cnt - cnt0); end
  endtask

  task automatic test_stall();
    int cnt0 = a_done_cnt;
    int n = 0;
    for (int i = 0; i < AH*AW; i++) fa[i] = DW'(i);
    a_out_ready = 1'b0;
    fork
      begin
        drive_frame_a(AH*AW, AH*AW-1);
      end
      begin
        while (!a_out_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 10; k++) begin
          checks++;
          if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== DW'(5) || a_out_addr !== '0) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got valid=%b ready=%b data=%0d addr=%0d want valid=1 ready=0 data=5 addr=0",
                     k, a_out_valid, a_in_ready, a_out_data, a_out_addr);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    wait_a(cnt0);
    checks += 2;
    if (exp_a.size() != 0) begin failures++; $display("FAIL stall_missing got pending=%0d want 0", exp_a.size()); end
    if (a_done_cnt != cnt0 + 1) begin failures++; $display("FAIL stall_done_count got=%0d want=1", a_done_cnt - cnt0); end
  endtask

  task automatic test_err();
    int cnt0 = a_done_cnt;
    for (int i = 0; i < AH*AW; i++) fa[i] = DW'(i);
    drive_frame_a(6, 5);
    wait_a(cnt0);
    checks++;
    if (a_err !== 1'b1) begin failures++; $display("FAIL err_early_last got=%b want=1", a_err); end
    cnt0 = a_done_cnt;
    drive_frame_a(AH*AW, AH*AW-1);
    wait_a(cnt0);
    checks += 2;
    if (a_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", a_err); end
    if (exp_a.size() != 0) begin failures++; $display("FAIL err_next_missing got pending=%0d want 0", exp_a.size()); end
  endtask

  task automatic test_abort();
    int cnt0 = a_done_cnt;
    for (int i = 0; i < AH*AW; i++) fa[i] = DW'(i);
    drive_frame_a(9, -1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks += 2;
    if (a_err !== 1'b0) begin failures++; $display("FAIL abort_async_err got=%b want=0", a_err); end
    if (a_out_valid !== 1'b0) begin failures++; $display("FAIL abort_async_valid got=%b want=0", a_out_valid); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks += 2;
    if (a_done_cnt != cnt0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", a_done_cnt - cnt0); end
    if (exp_a.size() != 0) begin failures++; $display("FAIL abort_partial got pending=%0d want 0", exp_a.size()); end
    @(posedge clk); #1;
    drive_frame_a(AH*AW, AH*AW-1);
    wait_a(cnt0);
    checks += 2;
    if (exp_a.size() != 0) begin failures++; $display("FAIL abort_next_missing got pending=%0d want 0", exp_a.size()); end
    if (a_done_cnt != cnt0 + 1) begin failures++; $display("FAIL abort_next_done got=%0d want=1", a_done_cnt - cnt0); end
  endtask

  task automatic test_random28();
    bit stop = 1'b0;
    int cnt0 = b_done_cnt;
    int n = 0;
    for (int i = 0; i < BH*BW; i++) fb[i] = DW'($urandom);
    fork
      begin
        for (int i = 0; i < BH*BW; i++) begin
          int r = i / BW;
          int c = i % BW;
          if ((r % 2 == 1) && (c % 2 == 1))
            exp_b.push_back(exp_t'{max4(fb[i-BW-1], fb[i-BW], fb[i-1], fb[i]), (r/2)*(BW/2) + c/2});
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_b(fb[i], i == BH*BW-1);
        end
        while (b_done_cnt == cnt0 && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          b_out_ready = ($urandom_range(0, 2) != 0);
        end
        b_out_ready = 1'b1;
      end
    join
    checks += 4;
    if (b_out_cnt != (BH/2)*(BW/2)) begin failures++; $display("FAIL rand_out_count got=%0d want=%0d", b_out_cnt, (BH/2)*(BW/2)); end
    if (exp_b.size() != 0) begin failures++; $display("FAIL rand_missing got pending=%0d want 0", exp_b.size()); end
    if (b_done_cnt != cnt0 + 1) begin failures++; $display("FAIL rand_done_count got=%0d want=1", b_done_cnt - cnt0); end
    if (b_err !== 1'b0) begin failures++; $display("FAIL rand_err got=%b want=0", b_err); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no completion want completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_stall();
    test_err();
    test_abort();
    test_random28();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
